// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller.
// 2^INDEX_BITS lines of 8 x 16-bit words, zero-latency hit path, blocking
// line fill (8 back-to-back word reads, in-order responses, no early restart).
// Optional hit/miss statistics counters enabled by macro ICACHE_STATS_EN.
module icache_ctrl #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        inval,
   output logic [15:0] rd_data,
   output logic        stall,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        mem_valid,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 12 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   // Control state
   state_t                  state_q, state_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic                    abort_q, abort_d;
   logic [2:0]              req_cnt_q, req_cnt_d;
   logic [2:0]              rsp_cnt_q, rsp_cnt_d;
   logic [TAG_BITS-1:0]     tag_lat_q, tag_lat_d;
   logic [INDEX_BITS-1:0]   idx_lat_q, idx_lat_d;
   logic                    mem_rd_q, mem_rd_d;
   logic [15:0]             mem_addr_q, mem_addr_d;

   // Tag and data storage; contents are only meaningful where valid is set
   logic [TAG_BITS-1:0]     tag_mem  [LINES];
   logic [15:0]             data_mem [LINES*8];

   // Address fields of the current fetch
   logic [INDEX_BITS-1:0]   addr_idx;
   logic [TAG_BITS-1:0]     addr_tag;
   logic                    addr_unused;
   logic                    lookup_hit;
   logic                    fill_write;
   logic                    fill_done;

   assign addr_idx    = addr[3+INDEX_BITS:4];
   assign addr_tag    = addr[15:4+INDEX_BITS];
   assign addr_unused = addr[0];

   // Tag compare is combinational so a hit returns data in the same cycle
   assign lookup_hit = req & valid_q[addr_idx] & (tag_mem[addr_idx] == addr_tag);
   assign rd_data    = data_mem[{addr_idx, addr[3:1]}];
   assign stall      = (state_q == IDLE) ? (req & ~lookup_hit) : 1'b1;

   // Responses only count while a fill is in flight; stray ones in IDLE are dropped
   assign fill_write = (state_q != IDLE) & mem_valid;
   assign fill_done  = fill_write & (rsp_cnt_q == 3'd7);

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;

   // Next-state logic for the fill sequencer, valid bits and memory strobe
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      abort_d    = abort_q;
      req_cnt_d  = req_cnt_q;
      rsp_cnt_d  = rsp_cnt_q;
      tag_lat_d  = tag_lat_q;
      idx_lat_d  = idx_lat_q;
      mem_rd_d   = mem_rd_q;
      mem_addr_d = mem_addr_q;

      case (state_q)
         IDLE: begin
            if (req & ~lookup_hit & ~inval) begin
               state_d    = FILL;
               tag_lat_d  = addr_tag;
               idx_lat_d  = addr_idx;
               req_cnt_d  = 3'd0;
               mem_rd_d   = 1'b1;
               mem_addr_d = {addr_tag, addr_idx, 3'd0, 1'b0};
            end
         end
         FILL: begin
            if (req_cnt_q == 3'd7) begin
               // Memory latency is at least one cycle, so the last response is still pending
               state_d    = DRAIN;
               req_cnt_d  = 3'd0;
               mem_rd_d   = 1'b0;
               mem_addr_d = 16'h0000;
            end else begin
               req_cnt_d  = req_cnt_q + 3'd1;
               mem_addr_d = {tag_lat_q, idx_lat_q, req_cnt_q + 3'd1, 1'b0};
            end
         end
         DRAIN: begin
            state_d = DRAIN;
         end
         default: begin
            state_d    = IDLE;
            mem_rd_d   = 1'b0;
            mem_addr_d = 16'h0000;
         end
      endcase

      if (fill_write) begin
         rsp_cnt_d = rsp_cnt_q + 3'd1;
      end

      if (fill_done) begin
         state_d = IDLE;
         abort_d = 1'b0;
         if (!abort_q) begin
            valid_d[idx_lat_q] = 1'b1;
         end
      end

      // Invalidate wins over a completing fill; a fill in flight is marked stale
      if (inval) begin
         valid_d = '0;
         if ((state_q != IDLE) && !fill_done) begin
            abort_d = 1'b1;
         end
      end
   end

   // Fill sequencer state and registered memory-request outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         abort_q    <= 1'b0;
         req_cnt_q  <= 3'd0;
         rsp_cnt_q  <= 3'd0;
         tag_lat_q  <= '0;
         idx_lat_q  <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         abort_q    <= abort_d;
         req_cnt_q  <= req_cnt_d;
         rsp_cnt_q  <= rsp_cnt_d;
         tag_lat_q  <= tag_lat_d;
         idx_lat_q  <= idx_lat_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // Line storage: response words land in order, tag written when the line completes
   always_ff @(posedge clk) begin
      if (fill_write) begin
         data_mem[{idx_lat_q, rsp_cnt_q}] <= mem_data;
      end
      if (fill_done) begin
         tag_mem[idx_lat_q] <= tag_lat_q;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   // Saturating statistics: hits per serviced IDLE cycle, misses per fill started
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if ((state_q == IDLE) && lookup_hit && (hit_cnt_q != 16'hFFFF)) begin
         hit_cnt_d = hit_cnt_q + 16'd1;
      end
      if ((state_q == IDLE) && (state_d == FILL) && (miss_cnt_q != 16'hFFFF)) begin
         miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= 16'h0000;
         miss_cnt_q <= 16'h0000;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = 16'h0000;
   assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: randomized self-checking bench for icache_ctrl.
// A fixed-latency in-order memory responder feeds fills; a line-level model
// (valid/tag per line, memory contents from a hash) predicts hits, bursts,
// stall length, returned words and the statistics counters.
module tb_icache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [15:0] addr;
   logic        inval;
   logic [15:0] rd_data;
   logic        stall;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_data = 16'h0000;
   logic        mem_valid = 1'b0;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .addr      (addr),
      .inval     (inval),
      .rd_data   (rd_data),
      .stall     (stall),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_valid (mem_valid),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   // ---------------- memory responder ----------------
   int          lat  = 4;
   int          cyc  = 0;
   bit          spur = 1'b0;
   logic [15:0] seed = 16'h0000;
   int          q_due[$];
   logic [15:0] q_addr[$];

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] w;
      w = {a[15:1], 1'b0};
      return (w * 16'h6D2B) ^ seed ^ 16'h1357;
   endfunction

   // Requests seen in a cycle are answered exactly lat cycles later, in order
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_rd === 1'b1) begin
         q_due.push_back(cyc + lat);
         q_addr.push_back(mem_addr);
      end
      mem_valid = 1'b0;
      mem_data  = 16'($urandom);
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         mem_valid = 1'b1;
         mem_data  = mem_word(q_addr[0]);
         void'(q_due.pop_front());
         void'(q_addr.pop_front());
      end else if (spur) begin
         mem_valid = 1'b1;
      end
   end

   // ---------------- line-level reference model ----------------
   bit         m_valid[16];
   logic [7:0] m_tag[16];
   int         exp_hits   = 0;
   int         exp_misses = 0;

   function automatic bit model_hit(input logic [15:0] a);
      return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[15:8]);
   endfunction

   function automatic logic [15:0] exp_stat(input int n);
`ifdef ICACHE_STATS_EN
      if (n > 65535) return 16'hFFFF;
      return 16'(n);
`else
      if (n < 0) return 16'h0001;
      return 16'h0000;
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   // One fetch transaction: predict hit or a full fill and check it cycle by cycle
   task automatic access(input logic [15:0] a, input bit abort, input bit garble);
      logic [15:0] base;
      int          nrd;
      int          drop;
      int          exp_drop;
      int          exp_nrd;
      base = {a[15:4], 4'h0};
      @(posedge clk); #1;
      req = 1'b1; addr = a; inval = 1'b0;
      @(negedge clk);
      if (model_hit(a)) begin
         checks++;
         if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall addr=%h stall=%b expected 0", a, stall); end
         checks++;
         if (rd_data !== mem_word(a)) begin errors++; $display("FAIL hit_data addr=%h rd_data=%h expected %h", a, rd_data, mem_word(a)); end
         checks++;
         if (mem_rd !== 1'b0) begin errors++; $display("FAIL hit_mem_rd addr=%h mem_rd=%b expected 0", a, mem_rd); end
         exp_hits++;
         $display("hit  addr=%h rd_data=%h", a, rd_data);
      end else begin
         checks++;
         if (stall !== 1'b1) begin errors++; $display("FAIL miss_stall addr=%h stall=%b expected 1", a, stall); end
         exp_misses++;
         exp_drop = abort ? 2 * (9 + lat) : (9 + lat);
         exp_nrd  = abort ? 16 : 8;
         nrd  = 0;
         drop = -1;
         for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            if (garble && c <= 8) begin
               req  = 1'($urandom);
               addr = 16'($urandom);
            end else begin
               req  = 1'b1;
               addr = a;
            end
            inval = (abort && c == 3);
            if (abort && c == 3) model_clear();
            @(negedge clk);
            if (mem_rd === 1'b1) begin
               checks++;
               if (mem_addr !== base + 16'(2 * (nrd % 8))) begin
                  errors++;
                  $display("FAIL burst_addr addr=%h beat=%0d mem_addr=%h expected %h", a, nrd, mem_addr, base + 16'(2 * (nrd % 8)));
               end
               nrd++;
            end else begin
               checks++;
               if (mem_addr !== 16'h0000) begin errors++; $display("FAIL idle_mem_addr addr=%h mem_addr=%h expected 0000", a, mem_addr); end
            end
            if (stall === 1'b0) begin
               drop = c;
               break;
            end
         end
         inval = 1'b0;
         checks++;
         if (drop < 0) begin
            errors++;
            $display("FAIL fill_timeout addr=%h stall still %b after 200 cycles, expected 0", a, stall);
         end else begin
            checks++;
            if (drop != exp_drop) begin errors++; $display("FAIL stall_len addr=%h stall_cycles=%0d expected %0d", a, drop, exp_drop); end
            checks++;
            if (nrd != exp_nrd) begin errors++; $display("FAIL burst_len addr=%h reads=%0d expected %0d", a, nrd, exp_nrd); end
            checks++;
            if (rd_data !== mem_word(a)) begin errors++; $display("FAIL fill_data addr=%h rd_data=%h expected %h", a, rd_data, mem_word(a)); end
         end
         if (abort) exp_misses++;
         m_valid[a[7:4]] = 1'b1;
         m_tag[a[7:4]]   = a[15:8];
         exp_hits++;
         $display("miss addr=%h abort=%0b lat=%0d stall_cycles=%0d reads=%0d rd_data=%h", a, abort, lat, drop, nrd, rd_data);
      end
   endtask

   task automatic idle_cycles(input int n, input bit spurious);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req = 1'b0; inval = 1'b0; spur = spurious;
         @(negedge clk);
         checks++;
         if (stall !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL idle stall=%b mem_rd=%b expected 0 0", stall, mem_rd);
         end
         spur = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; req = 1'b1; addr = 16'h0000; inval = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall stall=%b expected 1", stall); end
      checks++;
      if (mem_rd !== 1'b0 || mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem mem_rd=%b mem_addr=%h expected 0 0000", mem_rd, mem_addr); end
      checks++;
      if (hit_cnt !== 16'h0000 || miss_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt hit=%h miss=%h expected 0000 0000", hit_cnt, miss_cnt); end
      req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      exp_hits = 0; exp_misses = 0;
      $display("reset released");
   endtask

   task automatic test_first_fill();
      lat = 4;
      access(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_hit();
      access(16'h0006, 1'b0, 1'b0);
      access(16'h000F, 1'b0, 1'b0);
   endtask

   task automatic test_conflict();
      access(16'h0100, 1'b0, 1'b0);
      access(16'h0000, 1'b0, 1'b0);
      access(16'h0002, 1'b0, 1'b0);
   endtask

   task automatic test_inval_idle();
      @(posedge clk); #1;
      req = 1'b1; addr = 16'h0004; inval = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rd_data !== mem_word(16'h0004)) begin
         errors++;
         $display("FAIL inval_hit stall=%b rd_data=%h expected 0 %h", stall, rd_data, mem_word(16'h0004));
      end
      exp_hits++;
      model_clear();
      $display("inval with hit addr=0004 rd_data=%h", rd_data);
      access(16'h0004, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      access(16'h0040, 1'b1, 1'b0);
      access(16'h0042, 1'b0, 1'b0);
   endtask

   task automatic test_reset_drain();
      lat = 4;
      @(posedge clk); #1;
      req = 1'b1; addr = 16'h0230; inval = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0; req = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_rd !== 1'b0 || mem_addr !== 16'h0000 || stall !== 1'b0) begin
         errors++;
         $display("FAIL drain_reset mem_rd=%b mem_addr=%h stall=%b expected 0 0000 0", mem_rd, mem_addr, stall);
      end
      checks++;
      if (hit_cnt !== 16'h0000 || miss_cnt !== 16'h0000) begin errors++; $display("FAIL drain_reset_cnt hit=%h miss=%h expected 0000 0000", hit_cnt, miss_cnt); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      exp_hits = 0; exp_misses = 0;
      idle_cycles(10, 1'b0);
      $display("reset during drain, leftover responses flushed");
      access(16'h0230, 1'b0, 1'b0);
      access(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_stats();
      @(posedge clk); #1;
      rst_n = 1'b0; req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      exp_hits = 0; exp_misses = 0;
      access(16'h0500, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) access(16'h0500 + 16'(2 * i), 1'b0, 1'b0);
      idle_cycles(1, 1'b0);
      checks++;
      if (hit_cnt !== exp_stat(exp_hits)) begin errors++; $display("FAIL stats_hit hit_cnt=%0d expected %0d", hit_cnt, exp_stat(exp_hits)); end
      checks++;
      if (miss_cnt !== exp_stat(exp_misses)) begin errors++; $display("FAIL stats_miss miss_cnt=%0d expected %0d", miss_cnt, exp_stat(exp_misses)); end
      $display("stats hit_cnt=%0d miss_cnt=%0d", hit_cnt, miss_cnt);
   endtask

   task automatic test_random();
      logic [15:0] a;
      for (int n = 0; n < 70; n++) begin
         lat = int'($urandom_range(1, 6));
         a = {8'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 4'($urandom)};
         access(a, ($urandom_range(0, 9) == 0), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)), 1'($urandom));
      end
      idle_cycles(1, 1'b0);
      checks++;
      if (hit_cnt !== exp_stat(exp_hits)) begin errors++; $display("FAIL random_hit_cnt hit_cnt=%0d expected %0d", hit_cnt, exp_stat(exp_hits)); end
      checks++;
      if (miss_cnt !== exp_stat(exp_misses)) begin errors++; $display("FAIL random_miss_cnt miss_cnt=%0d expected %0d", miss_cnt, exp_stat(exp_misses)); end
   endtask

   initial begin
      seed = 16'($urandom);
      test_reset();
      test_first_fill();
      test_hit();
      test_conflict();
      test_inval_idle();
      test_abort();
      test_reset_drain();
      test_stats();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
